// File: rtl/i2c_pkg.sv
// Shared types and constants for the i2c_master_ctrl codebase slice.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK,
        RSTART, RADDR, RADDR_ACK, RDATA, MACK, STOP
    } i2c_state_t;

    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;
    localparam logic I2C_ACK   = 1'b0;
    localparam logic I2C_NACK  = 1'b1;

    localparam int PHASES = 4;

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit tick generator: pulses every CLK_DIV clk and advances a 2-bit bit phase.
module i2c_tick_gen
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        stall,
    output logic                        tick,
    output logic [$clog2(PHASES)-1:0]   phase
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = !clr && !stall && (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            phase <= '0;
        end else if (clr) begin
            cnt   <= '0;
            phase <= '0;
        end else if (!stall) begin
            if (cnt == LAST) begin
                cnt   <= '0;
                phase <= phase + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Register-addressed I2C master (write, or read via repeated START) with NACK reporting.
// Optional macro I2C_CLOCK_STRETCH_EN: honour slave clock stretching during SCL-high phases.
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter  int CLK_DIV    = 25,
    parameter  int DATA_BYTES = 4,
    localparam int DW         = 8 * DATA_BYTES
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [6:0]    ext_slave_address_in,
    input  logic          ext_read_write_in,
    input  logic [7:0]    ext_register_address_in,
    input  logic [DW-1:0] ext_data_in,
    output logic [DW-1:0] ext_data_out,
    output logic          busy,
    output logic          done,
    output logic          ack_error,
    output logic          scl_oe,
    output logic          sda_oe,
    input  logic          scl_i,
    input  logic          sda_i
);

    localparam logic [2:0] LAST_BYTE = 3'(DATA_BYTES - 1);

    i2c_state_t    state, state_n;
    logic          tick, stall, bit_end, samp_en, samp, last_byte;
    logic [1:0]    phase;
    logic [6:0]    addr_q;
    logic          rw_q;
    logic [7:0]    reg_q, tx_byte;
    logic [DW-1:0] wdata_q, rdata_q;
    logic [2:0]    bit_cnt, byte_cnt;

    i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clr   (state == IDLE),
        .stall (stall),
        .tick  (tick),
        .phase (phase)
    );

`ifdef I2C_CLOCK_STRETCH_EN
    // Released SCL still reads low: the slave is stretching, so freeze the bit timing.
    assign stall = phase[1] && !scl_oe && !scl_i;
`else
    logic unused_scl;
    assign unused_scl = scl_i;
    assign stall      = 1'b0;
`endif

    assign bit_end   = tick && (phase == 2'd3);
    assign samp_en   = tick && (phase == 2'd2);
    assign last_byte = (byte_cnt == LAST_BYTE);
    assign busy      = (state != IDLE);

    always_comb begin
        tx_byte = 8'hff;
        case (state)
            ADDR:    tx_byte = {addr_q, I2C_WRITE};
            REG:     tx_byte = reg_q;
            WDATA:   tx_byte = wdata_q[DW-1 -: 8];
            RADDR:   tx_byte = {addr_q, I2C_READ};
            default: tx_byte = 8'hff;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (en) state_n = START;
            START:     if (bit_end) state_n = ADDR;
            ADDR:      if (bit_end && bit_cnt == 3'd0) state_n = ADDR_ACK;
            ADDR_ACK:  if (bit_end) state_n = (samp == I2C_NACK) ? STOP : REG;
            REG:       if (bit_end && bit_cnt == 3'd0) state_n = REG_ACK;
            REG_ACK:   if (bit_end) state_n = (samp == I2C_NACK) ? STOP :
                                              (rw_q == I2C_READ) ? RSTART : WDATA;
            WDATA:     if (bit_end && bit_cnt == 3'd0) state_n = WDATA_ACK;
            WDATA_ACK: if (bit_end) state_n = (samp == I2C_NACK || last_byte) ? STOP : WDATA;
            RSTART:    if (bit_end) state_n = RADDR;
            RADDR:     if (bit_end && bit_cnt == 3'd0) state_n = RADDR_ACK;
            RADDR_ACK: if (bit_end) state_n = (samp == I2C_NACK) ? STOP : RDATA;
            RDATA:     if (bit_end && bit_cnt == 3'd0) state_n = MACK;
            MACK:      if (bit_end) state_n = last_byte ? STOP : RDATA;
            STOP:      if (bit_end) state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // SCL is low in phases 0-1 of every bit except START, which follows an idle (high) bus.
    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (state)
            START:  sda_oe = phase[1];
            RSTART: begin scl_oe = !phase[1]; sda_oe = (phase == 2'd3); end
            STOP:   begin scl_oe = !phase[1]; sda_oe = (phase != 2'd3); end
            ADDR, REG, WDATA, RADDR: begin
                scl_oe = !phase[1];
                sda_oe = !tx_byte[bit_cnt];
            end
            MACK:   begin scl_oe = !phase[1]; sda_oe = !last_byte; end
            ADDR_ACK, REG_ACK, WDATA_ACK, RADDR_ACK, RDATA: scl_oe = !phase[1];
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q       <= '0;
            rw_q         <= 1'b0;
            reg_q        <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            bit_cnt      <= '0;
            byte_cnt     <= '0;
            samp         <= 1'b0;
            ack_error    <= 1'b0;
            done         <= 1'b0;
            ext_data_out <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && en) begin
                addr_q    <= ext_slave_address_in;
                rw_q      <= ext_read_write_in;
                reg_q     <= ext_register_address_in;
                wdata_q   <= ext_data_in;
                ack_error <= 1'b0;
                bit_cnt   <= 3'd7;
                byte_cnt  <= '0;
            end
            if (samp_en) samp <= sda_i;
            if (samp_en && state == RDATA) rdata_q <= {rdata_q[DW-2:0], sda_i};
            if (bit_end) begin
                case (state)
                    // Down-counter wraps 0 -> 7, ready for the next byte.
                    ADDR, REG, WDATA, RADDR, RDATA: bit_cnt <= bit_cnt - 3'd1;
                    ADDR_ACK, REG_ACK, RADDR_ACK:   if (samp == I2C_NACK) ack_error <= 1'b1;
                    WDATA_ACK: begin
                        if (samp == I2C_NACK) begin
                            ack_error <= 1'b1;
                        end else begin
                            wdata_q  <= wdata_q << 8;
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end
                    MACK: byte_cnt <= byte_cnt + 3'd1;
                    STOP: begin
                        done <= 1'b1;
                        if (rw_q == I2C_READ && !ack_error) ext_data_out <= rdata_q;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Scoreboard bench for i2c_master_ctrl against a byte-register I2C slave model at 7'h63.
`timescale 1ns/1ps
module tb_i2c_master_ctrl;

    localparam int CLK_DIV = 4;
    localparam int DATA_BYTES = 4;
    localparam int DW = 32;
    localparam int BITP = 4 * CLK_DIV;
    localparam logic [6:0] SLV = 7'b110_0011;

    logic clk = 1'b0, rst = 1'b0, en = 1'b0;
    logic [6:0] s_addr = '0;
    logic rw = 1'b0;
    logic [7:0] r_addr = '0;
    logic [DW-1:0] d_in = '0;
    logic [DW-1:0] d_out;
    logic busy, done, ack_error, scl_oe, sda_oe;
    logic slv_scl_low = 1'b0, slv_sda_low = 1'b0;
    logic scl_bus, sda_bus;

    assign scl_bus = ~(scl_oe | slv_scl_low);
    assign sda_bus = ~(sda_oe | slv_sda_low);

    always #5 clk = ~clk;

    i2c_master_ctrl #(.CLK_DIV(CLK_DIV), .DATA_BYTES(DATA_BYTES)) dut (
        .clk(clk), .rst(rst), .en(en),
        .ext_slave_address_in(s_addr), .ext_read_write_in(rw),
        .ext_register_address_in(r_addr), .ext_data_in(d_in),
        .ext_data_out(d_out), .busy(busy), .done(done), .ack_error(ack_error),
        .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_i(scl_bus), .sda_i(sda_bus)
    );

    typedef struct { string name; logic err; logic [DW-1:0] dout; int lat; } exp_t;
    exp_t sb[$];

    int checks = 0, errors = 0, n_done = 0;
    longint t_acc = 0;
    int starts = 0, rises = 0;
    logic [3:0] mack_log = '0;
    bit stretch_arm = 1'b0;
    logic [7:0] mem [16];
    logic [7:0] memx [16];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic check_mem(input string nm);
        int bad;
        bad = 0;
        for (int i = 0; i < 16; i++) if (mem[i] !== memx[i]) bad++;
        check(nm, 64'(bad), 64'd0);
    endtask

    function automatic logic [7:0] rd(input int p);
        return (p < 16) ? mem[p] : 8'hff;
    endfunction

    // Monitor: every done pulse pops one expected transaction.
    initial begin
        exp_t e;
        int lat;
        forever begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done, expected none");
                end else begin
                    e = sb.pop_front();
                    lat = int'(($time - t_acc) / 10);
                    check({e.name, "_ack_error"}, 64'(ack_error), 64'(e.err));
                    check({e.name, "_data_out"}, 64'(d_out), 64'(e.dout));
                    check({e.name, "_busy_at_done"}, 64'(busy), 64'd0);
                    checks++;
                    if (lat < e.lat - 2 || lat > e.lat + 2) begin
                        errors++;
                        $display("FAIL %s_latency: got %0d clk, expected %0d clk", e.name, lat, e.lat);
                    end
                end
            end
        end
    end

    // Slave model, sampled on the falling system clock edge.
    initial begin
        int sst, nxt, bitc, ptr, str_cnt;
        logic [7:0] sh, tx;
        logic sc, sd, scl_p, sda_p, acking, mack, ack, str_on;
        sst = 0; nxt = 0; bitc = 0; ptr = 0; str_cnt = 0;
        sh = '0; tx = '0; scl_p = 1'b1; sda_p = 1'b1;
        acking = 1'b0; mack = 1'b0; ack = 1'b0; str_on = 1'b0;
        for (int i = 0; i < 16; i++) begin mem[i] = 8'ha0 + 8'(i); memx[i] = 8'ha0 + 8'(i); end
        forever begin
            @(negedge clk);
            sc = scl_bus; sd = sda_bus;
            if (!rst) begin
                sst = 0; acking = 1'b0; slv_sda_low = 1'b0; slv_scl_low = 1'b0; str_on = 1'b0;
            end else if (sc && scl_p && sda_p && !sd) begin
                starts++; sst = 1; bitc = 0; acking = 1'b0; slv_sda_low = 1'b0;
            end else if (sc && scl_p && !sda_p && sd) begin
                sst = 0; acking = 1'b0; slv_sda_low = 1'b0;
            end else if (sc && !scl_p) begin
                rises++;
                if (sst >= 1 && sst <= 3 && !acking && bitc < 8) begin
                    sh = {sh[6:0], sd}; bitc++;
                end else if (sst == 4 && bitc < 8) begin
                    bitc++;
                end else if (sst == 4 && bitc == 8) begin
                    mack = sd; mack_log = {mack_log[2:0], sd}; bitc = 9;
                end
            end else if (!sc && scl_p) begin
                if (acking) begin
                    acking = 1'b0; slv_sda_low = 1'b0; bitc = 0; sst = nxt;
                    if (stretch_arm && sst == 2) begin
                        slv_scl_low = 1'b1; str_on = 1'b1; str_cnt = 0; stretch_arm = 1'b0;
                    end
                    if (sst == 4) begin tx = rd(ptr); ptr++; slv_sda_low = !tx[7]; end
                end else if (sst >= 1 && sst <= 3 && bitc == 8) begin
                    ack = 1'b0; nxt = 5;
                    case (sst)
                        1: if (sh[7:1] == SLV) begin ack = 1'b1; nxt = sh[0] ? 4 : 2; end
                        2: if (sh < 8'd16) begin ack = 1'b1; ptr = int'(sh); nxt = 3; end
                        3: if (ptr < 16) begin mem[ptr] = sh; ptr++; ack = 1'b1; nxt = 3; end
                        default: ;
                    endcase
                    acking = 1'b1; slv_sda_low = ack;
                end else if (sst == 4) begin
                    if (bitc < 8) slv_sda_low = !tx[7-bitc];
                    else if (bitc == 8) slv_sda_low = 1'b0;
                    else if (!mack) begin tx = rd(ptr); ptr++; bitc = 0; slv_sda_low = !tx[7]; end
                    else begin sst = 5; slv_sda_low = 1'b0; end
                end
            end
            // Held long enough that the master's SCL-high phase stretches by exactly 37 clk.
            if (str_on) begin
                if (!scl_oe) str_cnt++;
                if (str_cnt == 38) begin slv_scl_low = 1'b0; str_on = 1'b0; end
            end
            scl_p = sc; sda_p = sd;
        end
    end

    task automatic issue(input string nm, input logic [6:0] a, input logic w_r, input logic [7:0] r,
                         input logic [DW-1:0] d, input bit push, input logic xe,
                         input logic [DW-1:0] xd, input int xl);
        @(negedge clk);
        if (push) sb.push_back('{nm, xe, xd, xl});
        starts = 0; rises = 0; mack_log = '0;
        s_addr = a; rw = w_r; r_addr = r; d_in = d; en = 1'b1;
        @(posedge clk); #1;
        t_acc = $time; en = 1'b0;
        check({nm, "_busy_rise"}, 64'(busy), 64'd1);
        check({nm, "_ack_error_cleared"}, 64'(ack_error), 64'd0);
    endtask

    task automatic wait_done(input string nm);
        int n0;
        n0 = n_done;
        for (int k = 0; k < 4000 && n_done == n0; k++) @(posedge clk);
        if (n_done == n0) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got no done, expected done within 4000 clk", nm);
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #12;
        check("reset_outputs", {59'd0, busy, done, ack_error, scl_oe, sda_oe}, 64'd0);
        check("reset_data_out", 64'(d_out), 64'd0);
        @(negedge clk); rst = 1'b1;
        repeat (3) @(posedge clk);

        // 1: wrong address -> NACK after address byte
        issue("t1_addr_nack", 7'b110_1011, 1'b0, 8'hbf, 32'h1234_58ae, 1, 1'b1, 32'h0, 11 * BITP);
        wait_done("t1");
        check("t1_scl_pulses", 64'(rises), 64'd10);
        check_mem("t1_slave_unchanged");

        // 2: register NACK -> no data bytes
        issue("t2_reg_nack", SLV, 1'b0, 8'hfb, 32'hdead_beef, 1, 1'b1, 32'h0, 20 * BITP);
        wait_done("t2");
        check("t2_scl_pulses", 64'(rises), 64'd19);
        check_mem("t2_slave_unchanged");

        // 3: full write, plus a stray en while busy
        issue("t3_write", SLV, 1'b0, 8'h0b, 32'h58ae_1234, 1, 1'b0, 32'h0, (20 + 9 * 4) * BITP);
        repeat (100) @(posedge clk);
        @(negedge clk); rw = 1'b1; r_addr = 8'h01; en = 1'b1;
        @(negedge clk); en = 1'b0;
        wait_done("t3");
        memx[11] = 8'h58; memx[12] = 8'hae; memx[13] = 8'h12; memx[14] = 8'h34;
        check_mem("t3_slave_written");
        check("t3_scl_pulses", 64'(rises), 64'd55);
        check("t3_single_start", 64'(starts), 64'd1);

        // 4: read back with repeated START
        issue("t4_read", SLV, 1'b1, 8'h0b, 32'h0, 1, 1'b0, 32'h58ae_1234, (30 + 9 * 4) * BITP);
        wait_done("t4");
        check("t4_repeated_start", 64'(starts), 64'd2);
        check("t4_master_ack_pattern", 64'(mack_log), 64'b0001);

        // 5: reset during RDATA
        issue("t5_abort", SLV, 1'b1, 8'h0b, 32'h0, 0, 1'b0, 32'h0, 0);
        repeat (29 * BITP + 40) @(posedge clk);
        #1;
        check("t5_busy_before_reset", 64'(busy), 64'd1);
        check("t5_data_before_reset", 64'(d_out), 64'h58ae_1234);
        #2 rst = 1'b0;
        #1;
        check("t5_lines_released", {62'd0, scl_oe, sda_oe}, 64'd0);
        check("t5_busy_cleared", 64'(busy), 64'd0);
        check("t5_data_cleared", 64'(d_out), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        repeat (3) @(posedge clk);

`ifdef I2C_CLOCK_STRETCH_EN
        // 6: slave stretches SCL after the address ACK
        stretch_arm = 1'b1;
        issue("t6_stretch", SLV, 1'b0, 8'h00, 32'hcafe_f00d, 1, 1'b0, 32'h0, (20 + 9 * 4) * BITP + 37);
        wait_done("t6");
        memx[0] = 8'hca; memx[1] = 8'hfe; memx[2] = 8'hf0; memx[3] = 8'h0d;
        check_mem("t6_slave_written");
`endif

        // 7: recovery write after the abort
        issue("t7_write", SLV, 1'b0, 8'h04, 32'h0102_0304, 1, 1'b0, 32'h0, (20 + 9 * 4) * BITP);
        wait_done("t7");
        memx[4] = 8'h01; memx[5] = 8'h02; memx[6] = 8'h03; memx[7] = 8'h04;
        check_mem("t7_slave_written");
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
